mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store access unit sitting directly upstream of the data-memory wrapper (64 KB word-addressed RAM, written and read on the inverted clock).
- Accepts one memory request at a time from the MEM stage.
- Converts byte, halfword and word loads and stores into word RAM accesses. Sub-word stores use read-modify-write.
- Returns sign- or zero-extended load data and an error flag through a valid/ready response.

Parameters:
- ADDR_W, 16, byte-address bits decoded (64 KB). Higher address bits must be zero.
- DATA_W, 32, word width. Fixed at 32.

Ports:
- clock  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range access.
- Memory_write  out  1  RAM write enable.
- Address  out  32  RAM byte address, word-aligned (bits[1:0]=0).
- Write_data  out  32  RAM write word.
- Read_data  in  32  RAM read word.

Behaviour:
- **Reset** (reset=0, async): state=IDLE. req_ready=0 while reset is asserted, 1 after. resp_valid=0, resp_rdata=0, resp_err=0, Memory_write=0, Address=0, Write_data=0. Reset mid-access abandons the access; no partial write completes after reset asserts.
- **FSM states:** IDLE, RD, WR, RESP. req_ready=1 only in IDLE.
- **Accept:** in IDLE, req_valid=1 latches op, addr, wdata.
- **Error check at accept:**
  - err = addr[31:ADDR_W]!=0, OR (LW/SW and addr[1:0]!=0), OR (LH/LHU/SH and addr[0]!=0).
  - err → RESP with resp_err=1, resp_rdata=0. No RAM access.
- **Transitions on accept (no error):** LW/LH/LHU/LB/LBU/SH/SB → RD. SW → WR.
- **RD (1 cycle):** Address={addr[31:2],2'b00}, Memory_write=0. RAM samples on the falling edge, so Read_data is valid at the rising edge ending RD; the unit registers it there.
  - Loads → RESP.
  - SH/SB → WR with the merged word.
- **WR (1 cycle):** Memory_write=1, Address held, Write_data = full word (SW) or merged word (SH/SB) → RESP. Memory_write is 1 in no other state.
- **Byte lanes:** little-endian. Byte offset k occupies bits[8k+7:8k]; halfword offset 0 → [15:0], offset 2 → [31:16].
- **Merge:** only the addressed lane is replaced with req_wdata[7:0] or [15:0]; other lanes keep the RAM word read in RD.
- **Load extension:** LB/LH sign-extend from the lane MSB; LBU/LHU zero-extend; LW passes the word through.
- **RESP:** resp_valid=1; resp_rdata/resp_err stable until resp_ready=1. Handshake edge → IDLE, resp_valid=0.
- **Throughput:** req_ready returns the cycle after the handshake. No request overlap; back-to-back accesses see prior writes.
- **Latency, accept edge to resp_valid:** load 2 cycles; SW 2; SH/SB 3; error 1.
- Address and Write_data are registered outputs, stable across the RAM falling-edge sample.

Test Plan:
- Reset release, then SW addr=0x0000_0010 data=0xDEADBEEF, then LW 0x10 → Memory_write pulses exactly 1 cycle with Address=0x10; load resp_rdata=0xDEADBEEF, resp_err=0, 2-cycle latency.
- After the above: SB addr=0x12 data=0x0000_0055, then LW 0x10 → 0xDE55BEEF. SH addr=0x10 data=0x1234 → LW reads 0xDE551234.
- Word 0x8001_80FF at 0x20: LB 0x20 → 0xFFFFFFFF; LBU 0x20 → 0x000000FF; LH 0x22 → 0xFFFF8001; LHU 0x22 → 0x00008001; LB 0x21 → 0xFFFFFF80.
- LW 0x21, SH 0x13, SW 0x0001_0000 → resp_err=1, resp_rdata=0, 1-cycle latency, Memory_write never asserts; RAM contents unchanged on readback.
- Hold resp_ready=0 for 5 cycles on a load → resp_valid and resp_rdata stay constant, req_ready=0, new req_valid ignored. Accepted on the cycle after resp_ready=1.
- Assert reset during WR of an SB → Memory_write drops immediately; all outputs at reset values; after release, first request accepted normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word RAM: sub-word stores are done as read-modify-write, and errors are answered without touching the RAM.
// Latency from accept edge to resp_valid: error 1, load/SW 2, SH/SB 3. Requests wait while req_ready=0 and the response is held until resp_ready.
module mem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              Memory_write,
  output logic [31:0]       Address,
  output logic [DATA_W-1:0] Write_data,
  input  logic [DATA_W-1:0] Read_data
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          off_q, off_d;
  logic [15:0]         st_dat_q, st_dat_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wr_dat_q, wr_dat_d;
  logic                acc_err;

  function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] op, input logic [1:0] off,
                                                 input logic [DATA_W-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'h0000, h};
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'h000000, b};
      default: load_ext = w;
    endcase
  endfunction

  // Only the addressed lane is replaced; the rest of the word comes from the RAM read.
  function automatic logic [DATA_W-1:0] merge_word(input logic [2:0] op, input logic [1:0] off,
                                                   input logic [DATA_W-1:0] w, input logic [15:0] d);
    logic [DATA_W-1:0] m;
    m = w;
    if (op == OP_SB) m[{off, 3'b000} +: 8] = d[7:0];
    else             m[{off[1], 4'b0000} +: 16] = d;
    merge_word = m;
  endfunction

  always_comb begin
    acc_err = (req_addr[31:ADDR_W] != '0)
           || (((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00))
           || (((req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH)) && req_addr[0]);
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    off_d        = off_q;
    st_dat_d     = st_dat_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we_d     = 1'b0;
    addr_d       = addr_q;
    wr_dat_d     = wr_dat_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d     = req_op;
          off_d    = req_addr[1:0];
          st_dat_d = req_wdata[15:0];
          if (acc_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            addr_d = {req_addr[31:2], 2'b00};
            if (req_op == OP_SW) begin
              state_d  = S_WR;
              mem_we_d = 1'b1;
              wr_dat_d = req_wdata;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        if ((op_q == OP_SH) || (op_q == OP_SB)) begin
          state_d  = S_WR;
          mem_we_d = 1'b1;
          wr_dat_d = merge_word(op_q, off_q, Read_data, st_dat_q);
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_ext(op_q, off_q, Read_data);
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_LW;
      off_q        <= 2'b00;
      st_dat_q     <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      addr_q       <= '0;
      wr_dat_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      off_q        <= off_d;
      st_dat_q     <= st_dat_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_we_q     <= mem_we_d;
      addr_q       <= addr_d;
      wr_dat_q     <= wr_dat_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign Memory_write = mem_we_q;
  assign Address      = addr_q;
  assign Write_data   = wr_dat_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a falling-edge word RAM model behind it.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        Memory_write;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data = '0;

  int n_vec = 0;
  int n_miscomp = 0;

  logic [31:0] mem [0:16383];

  mem_access_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .Memory_write(Memory_write), .Address(Address),
    .Write_data(Write_data), .Read_data(Read_data)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
  end

  // RAM samples on the falling edge, matching the inverted-clock wrapper.
  always @(negedge clock) begin
    if (Memory_write) mem[Address[15:2]] <= Write_data;
    Read_data <= mem[Address[15:2]];
  end

  // Issues one request with resp_ready=1 and reports what came back; lat counts the accept edge as 1.
  task automatic access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int wes, output logic [31:0] wa, output logic [31:0] wd);
    int guard;
    rd = '0; er = 1'b0; lat = 0; wes = 0; wa = '0; wd = '0;
    req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1; resp_ready = 1'b1;
    guard = 0;
    while (!req_ready) begin
      @(posedge clock); #1;
      guard++;
      if (guard > 20) begin
        n_vec++; n_miscomp++;
        $display("FAIL accept_timeout op=%0d addr=%h", op, a);
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    forever begin
      if (Memory_write) begin wes++; wa = Address; wd = Write_data; end
      if (resp_valid) break;
      if (lat > 20) begin
        n_vec++; n_miscomp++;
        $display("FAIL resp_timeout op=%0d addr=%h", op, a);
        return;
      end
      @(posedge clock); #1;
      lat++;
    end
    rd = resp_rdata; er = resp_err;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    n_vec++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || Memory_write !== 1'b0) begin
      n_miscomp++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b we=%b want 0 0 0", req_ready, resp_valid, Memory_write);
    end
    n_vec++;
    if (resp_rdata !== 32'h0 || resp_err !== 1'b0 || Address !== 32'h0 || Write_data !== 32'h0) begin
      n_miscomp++;
      $display("FAIL reset_data got rdata=%h err=%b addr=%h wdat=%h want zeros", resp_rdata, resp_err, Address, Write_data);
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_miscomp++;
      $display("FAIL reset_release_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd, wa, wd; logic er; int lat, wes;
    access(3'd5, 32'h10, 32'hDEADBEEF, rd, er, lat, wes, wa, wd);
    n_vec++;
    if (er !== 1'b0 || rd !== 32'h0 || lat != 2) begin
      n_miscomp++;
      $display("FAIL sw_resp got err=%b rdata=%h lat=%0d want 0 00000000 2", er, rd, lat);
    end
    n_vec++;
    if (wes != 1 || wa !== 32'h10 || wd !== 32'hDEADBEEF) begin
      n_miscomp++;
      $display("FAIL sw_write got pulses=%0d addr=%h data=%h want 1 00000010 deadbeef", wes, wa, wd);
    end
    access(3'd0, 32'h10, 32'h0, rd, er, lat, wes, wa, wd);
    n_vec++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 2 || wes != 0) begin
      n_miscomp++;
      $display("FAIL lw_after_sw got rdata=%h err=%b lat=%0d we=%0d want deadbeef 0 2 0", rd, er, lat, wes);
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd, wa, wd; logic er; int lat, wes;
    access(3'd7, 32'h12, 32'h00000055, rd, er, lat, wes, wa, wd);
    n_vec++;
    if (lat != 3 || wes != 1 || wa !== 32'h10 || wd !== 32'hDE55BEEF || er !== 1'b0) begin
      n_miscomp++;
      $display("FAIL sb_rmw got lat=%0d we=%0d addr=%h data=%h err=%b want 3 1 00000010 de55beef 0", lat, wes, wa, wd, er);
    end
    access(3'd0, 32'h10, 32'h0, rd, er, lat, wes, wa, wd);
    n_vec++;
    if (rd !== 32'hDE55BEEF) begin
      n_miscomp++;
      $display("FAIL lw_after_sb got %h want de55beef", rd);
    end
    access(3'd6, 32'h10, 32'hFFFF1234, rd, er, lat, wes, wa, wd);
    n_vec++;
    if (lat != 3 || wes != 1 || er !== 1'b0) begin
      n_miscomp++;
      $display("FAIL sh_rmw got lat=%0d we=%0d err=%b want 3 1 0", lat, wes, er);
    end
    access(3'd0, 32'h10, 32'h0, rd, er, lat, wes, wa, wd);
    n_vec++;
    if (rd !== 32'hDE551234) begin
      n_miscomp++;
      $display("FAIL lw_after_sh got %h want de551234", rd);
    end
  endtask

  logic [2:0]  ext_op  [5] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd3};
  logic [31:0] ext_adr [5] = '{32'h20, 32'h20, 32'h22, 32'h22, 32'h21};
  logic [31:0] ext_exp [5] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8001, 32'h00008001, 32'hFFFFFF80};

  task automatic test_load_ext();
    logic [31:0] rd, wa, wd; logic er; int lat, wes;
    access(3'd5, 32'h20, 32'h800180FF, rd, er, lat, wes, wa, wd);
    for (int i = 0; i < 5; i++) begin
      access(ext_op[i], ext_adr[i], 32'h0, rd, er, lat, wes, wa, wd);
      n_vec++;
      if (rd !== ext_exp[i] || er !== 1'b0 || lat != 2) begin
        n_miscomp++;
        $display("FAIL load_ext[%0d] op=%0d addr=%h got %h err=%b lat=%0d want %h 0 2",
                 i, ext_op[i], ext_adr[i], rd, er, lat, ext_exp[i]);
      end
    end
  endtask

  logic [2:0]  err_op  [3] = '{3'd0, 3'd6, 3'd5};
  logic [31:0] err_adr [3] = '{32'h21, 32'h13, 32'h00010000};

  task automatic test_errors();
    logic [31:0] rd, wa, wd; logic er; int lat, wes;
    for (int i = 0; i < 3; i++) begin
      access(err_op[i], err_adr[i], 32'hCAFEF00D, rd, er, lat, wes, wa, wd);
      n_vec++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || wes != 0) begin
        n_miscomp++;
        $display("FAIL err[%0d] got err=%b rdata=%h lat=%0d we=%0d want 1 00000000 1 0", i, er, rd, lat, wes);
      end
    end
    access(3'd0, 32'h10, 32'h0, rd, er, lat, wes, wa, wd);
    n_vec++;
    if (rd !== 32'hDE551234) begin
      n_miscomp++;
      $display("FAIL err_readback_10 got %h want de551234", rd);
    end
    access(3'd0, 32'h0, 32'h0, rd, er, lat, wes, wa, wd);
    n_vec++;
    if (rd !== 32'h0) begin
      n_miscomp++;
      $display("FAIL err_readback_00 got %h want 00000000", rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int guard;
    req_op = 3'd0; req_addr = 32'h10; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clock); #1;
    req_op = 3'd0; req_addr = 32'h20;
    guard = 0;
    while (!resp_valid && guard < 10) begin @(posedge clock); #1; guard++; end
    held = resp_rdata;
    n_vec++;
    if (resp_valid !== 1'b1 || held !== 32'hDE551234) begin
      n_miscomp++;
      $display("FAIL bp_first_resp got vld=%b rdata=%h want 1 de551234", resp_valid, held);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      n_vec++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDE551234 || req_ready !== 1'b0 || Memory_write !== 1'b0) begin
        n_miscomp++;
        $display("FAIL bp_hold[%0d] got vld=%b rdata=%h rdy=%b we=%b want 1 de551234 0 0",
                 i, resp_valid, resp_rdata, req_ready, Memory_write);
      end
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    n_vec++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_miscomp++;
      $display("FAIL bp_release got vld=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    n_vec++;
    if (req_ready !== 1'b0) begin
      n_miscomp++;
      $display("FAIL bp_next_accept got rdy=%b want 0", req_ready);
    end
    @(posedge clock); #1;
    n_vec++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h800180FF) begin
      n_miscomp++;
      $display("FAIL bp_next_resp got vld=%b rdata=%h want 1 800180ff", resp_valid, resp_rdata);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_wr();
    logic [31:0] rd, wa, wd; logic er; int lat, wes;
    access(3'd5, 32'h30, 32'h11223344, rd, er, lat, wes, wa, wd);
    req_op = 3'd7; req_addr = 32'h31; req_wdata = 32'hAA; req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    n_vec++;
    if (Memory_write !== 1'b1 || Write_data !== 32'h1122AA44) begin
      n_miscomp++;
      $display("FAIL rst_wr_entry got we=%b data=%h want 1 1122aa44", Memory_write, Write_data);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (Memory_write !== 1'b0 || Address !== 32'h0 || Write_data !== 32'h0 || resp_valid !== 1'b0 ||
        req_ready !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      n_miscomp++;
      $display("FAIL rst_mid_wr got we=%b addr=%h wdat=%h vld=%b rdy=%b rdata=%h err=%b want all zero",
               Memory_write, Address, Write_data, resp_valid, req_ready, resp_rdata, resp_err);
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    access(3'd0, 32'h30, 32'h0, rd, er, lat, wes, wa, wd);
    n_vec++;
    if (rd !== 32'h11223344 || er !== 1'b0 || lat != 2) begin
      n_miscomp++;
      $display("FAIL rst_readback got rdata=%h err=%b lat=%0d want 11223344 0 2", rd, er, lat);
    end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_subword_store();
    test_load_ext();
    test_errors();
    test_backpressure();
    test_reset_mid_wr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

endmodule
